// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: FSM encoding, data-processing opcodes, flag bit
// positions and opcode classification helpers.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;

   // Flag bit positions inside the 4-bit NZCV vector (shared with fetch).
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // TST/TEQ/CMP/CMN: flags only, never write the register file.
   function automatic logic is_test_op(input logic [3:0] opcode);
      return (opcode >= OP_TST) && (opcode <= OP_CMN);
   endfunction

   // Ops whose full NZCV comes from the adder; the rest are logical.
   function automatic logic is_arith_op(input logic [3:0] opcode);
      return ((opcode >= OP_SUB) && (opcode <= OP_RSC)) ||
             (opcode == OP_CMP) || (opcode == OP_CMN);
   endfunction

endpackage

// File: rtl/op2_imm_rotate.sv
// Immediate operand expander: 8-bit constant rotated right by twice the
// 4-bit rotate field.
module op2_imm_rotate (
   input  logic [11:0] i_imm12,
   output logic [31:0] o_imm32
);

   logic [31:0] w_imm_ext;
   logic [63:0] w_imm_dbl;
   logic [63:0] w_imm_shr;
   logic [4:0]  w_rot_amt;

   assign w_imm_ext = {24'd0, i_imm12[7:0]};
   assign w_rot_amt = {i_imm12[11:8], 1'b0};
   // Rotate by shifting a doubled copy and keeping the low word.
   assign w_imm_dbl = {w_imm_ext, w_imm_ext};
   assign w_imm_shr = w_imm_dbl >> w_rot_amt;
   assign o_imm32   = w_imm_shr[31:0];

endmodule

// File: rtl/instr_control_unit.sv
// Multi-cycle control unit for the data-processing instruction class:
// sequences fetch strobes, register read, execute and write-back, and owns
// the architectural NZCV flag register and the retired-instruction counter.
module instr_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [31:0]      IR,
   input  logic             W_IR_valid,
   input  logic [3:0]       alu_nzcv,
   input  logic             shift_carry,
   output logic             write_ir,
   output logic             write_pc,
   output logic [3:0]       rf_ra,
   output logic [3:0]       rf_rb,
   output logic [3:0]       rf_wa,
   output logic             rf_we,
   output logic [3:0]       alu_op,
   output logic             op2_imm,
   output logic [31:0]      imm32,
   output logic [1:0]       shift_type,
   output logic [4:0]       shift_amt,
   output logic [3:0]       NZCV,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t           r_state;
   logic [3:0]       r_nzcv;
   logic [CNT_W-1:0] r_retired;

   logic [3:0] w_opcode;
   logic       w_is_dp;
   logic       w_is_test;
   logic       w_flag_upd;
   logic       w_unused_cond;

   // Instruction field decode; condition is evaluated upstream in fetch.
   assign w_opcode      = IR[24:21];
   assign w_is_dp       = (IR[27:26] == 2'b00);
   assign w_is_test     = is_test_op(w_opcode);
   assign w_flag_upd    = IR[20] | w_is_test;
   assign w_unused_cond = ^IR[31:28];

   op2_imm_rotate u_imm (
      .i_imm12 (IR[11:0]),
      .o_imm32 (imm32)
   );

   // Operand fields follow IR directly; consumers qualify them by state.
   assign rf_ra      = IR[19:16];
   assign rf_rb      = IR[3:0];
   assign rf_wa      = IR[15:12];
   assign alu_op     = w_opcode;
   assign op2_imm    = IR[25];
   assign shift_type = IR[6:5];
   assign shift_amt  = IR[11:7];

   // Moore strobes decoded from the state register.
   assign write_ir = (r_state == ST_FETCH);
   assign write_pc = (r_state == ST_FETCH);
   assign illegal  = (r_state == ST_DECODE) && !w_is_dp;
   assign rf_we    = (r_state == ST_WB) && !w_is_test;

   assign NZCV    = r_nzcv;
   assign retired = r_retired;

   // State sequencing plus the flag and retire-count updates at WB exit.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_nzcv    <= 4'b0000;
         r_retired <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (run) r_state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (W_IR_valid) r_state <= ST_DECODE;
               else            r_state <= run ? ST_FETCH : ST_IDLE;
            end
            ST_DECODE: begin
               if (w_is_dp) r_state <= ST_EXEC;
               else         r_state <= run ? ST_FETCH : ST_IDLE;
            end
            ST_EXEC: begin
               r_state <= ST_WB;
            end
            ST_WB: begin
               if (w_flag_upd) begin
                  if (is_arith_op(w_opcode)) begin
                     r_nzcv <= alu_nzcv;
                  end else begin
                     r_nzcv[FLAG_N] <= alu_nzcv[FLAG_N];
                     r_nzcv[FLAG_Z] <= alu_nzcv[FLAG_Z];
                     r_nzcv[FLAG_C] <= shift_carry;
                  end
               end
               r_retired <= r_retired + CNT_W'(1);
               r_state   <= run ? ST_FETCH : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_control_unit.sv
// Directed bench for instr_control_unit. Each task starts at a falling edge
// with the DUT in FETCH (unless stated) and samples outputs on falling edges.
module tb_instr_control_unit;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic [31:0]      IR;
   logic             W_IR_valid;
   logic [3:0]       alu_nzcv;
   logic             shift_carry;
   logic             write_ir;
   logic             write_pc;
   logic [3:0]       rf_ra;
   logic [3:0]       rf_rb;
   logic [3:0]       rf_wa;
   logic             rf_we;
   logic [3:0]       alu_op;
   logic             op2_imm;
   logic [31:0]      imm32;
   logic [1:0]       shift_type;
   logic [4:0]       shift_amt;
   logic [3:0]       NZCV;
   logic             illegal;
   logic [CNT_W-1:0] retired;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instr_control_unit #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .IR          (IR),
      .W_IR_valid  (W_IR_valid),
      .alu_nzcv    (alu_nzcv),
      .shift_carry (shift_carry),
      .write_ir    (write_ir),
      .write_pc    (write_pc),
      .rf_ra       (rf_ra),
      .rf_rb       (rf_rb),
      .rf_wa       (rf_wa),
      .rf_we       (rf_we),
      .alu_op      (alu_op),
      .op2_imm     (op2_imm),
      .imm32       (imm32),
      .shift_type  (shift_type),
      .shift_amt   (shift_amt),
      .NZCV        (NZCV),
      .illegal     (illegal),
      .retired     (retired)
   );

   task automatic test_reset();
      rst_n = 1'b0; run = 1'b1;
      IR = 32'hE2911005; W_IR_valid = 1'b1; alu_nzcv = 4'b0000; shift_carry = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({write_ir, write_pc, rf_we, illegal} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_strobes: got wir/wpc/we/ill=%b want 0000", {write_ir, write_pc, rf_we, illegal});
      end
      n_tests++;
      if (NZCV !== 4'b0000) begin n_fail++; $display("FAIL reset_nzcv: got %b want 0000", NZCV); end
      n_tests++;
      if (retired !== '0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({write_ir, write_pc} !== 2'b11) begin
         n_fail++; $display("FAIL first_fetch: got wir/wpc=%b want 11", {write_ir, write_pc});
      end
   endtask

   task automatic test_adds();
      IR = 32'hE2911005; W_IR_valid = 1'b1; alu_nzcv = 4'b0000; shift_carry = 1'b0;
      @(negedge clk); // DECODE
      n_tests++;
      if ({write_ir, rf_ra, rf_rb} !== {1'b0, 4'd1, 4'd5}) begin
         n_fail++; $display("FAIL adds_decode: got wir=%b ra=%0d rb=%0d want 0 1 5", write_ir, rf_ra, rf_rb);
      end
      @(negedge clk); // EXEC
      n_tests++;
      if (imm32 !== 32'd5 || op2_imm !== 1'b1 || alu_op !== 4'h4 || rf_we !== 1'b0) begin
         n_fail++; $display("FAIL adds_exec: got imm=%h op2i=%b op=%h we=%b want 00000005 1 4 0", imm32, op2_imm, alu_op, rf_we);
      end
      @(negedge clk); // WB
      n_tests++;
      if (rf_we !== 1'b1 || rf_wa !== 4'd1) begin
         n_fail++; $display("FAIL adds_wb: got we=%b wa=%0d want 1 1", rf_we, rf_wa);
      end
      @(negedge clk); // FETCH
      n_tests++;
      if (write_ir !== 1'b1 || NZCV !== 4'b0000 || retired !== 16'd1) begin
         n_fail++; $display("FAIL adds_done: got wir=%b nzcv=%b ret=%0d want 1 0000 1", write_ir, NZCV, retired);
      end
   endtask

   task automatic test_cmp();
      IR = 32'hE3520000; W_IR_valid = 1'b1; alu_nzcv = 4'b0110;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (rf_we !== 1'b0) begin n_fail++; $display("FAIL cmp_no_write: cycle %0d got we=%b want 0", c, rf_we); end
      end
      @(negedge clk);
      n_tests++;
      if (write_ir !== 1'b1 || NZCV !== 4'b0110 || retired !== 16'd2) begin
         n_fail++; $display("FAIL cmp_done: got wir=%b nzcv=%b ret=%0d want 1 0110 2", write_ir, NZCV, retired);
      end
   endtask

   task automatic test_mov_rot();
      IR = 32'hE3A004FF; W_IR_valid = 1'b1; alu_nzcv = 4'b1111; shift_carry = 1'b1;
      @(negedge clk); // DECODE
      @(negedge clk); // EXEC
      n_tests++;
      if (imm32 !== 32'hFF000000 || alu_op !== 4'hD || op2_imm !== 1'b1) begin
         n_fail++; $display("FAIL mov_imm: got imm=%h op=%h op2i=%b want ff000000 d 1", imm32, alu_op, op2_imm);
      end
      @(negedge clk); // WB
      n_tests++;
      if (rf_we !== 1'b1 || rf_wa !== 4'd0) begin
         n_fail++; $display("FAIL mov_wb: got we=%b wa=%0d want 1 0", rf_we, rf_wa);
      end
      @(negedge clk);
      n_tests++;
      if (write_ir !== 1'b1 || NZCV !== 4'b0110 || retired !== 16'd3) begin
         n_fail++; $display("FAIL mov_done: got wir=%b nzcv=%b ret=%0d want 1 0110 3", write_ir, NZCV, retired);
      end
   endtask

   task automatic test_skip();
      IR = 32'hE2911005; W_IR_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({write_ir, write_pc, rf_we} !== 3'b110 || retired !== 16'd3) begin
         n_fail++; $display("FAIL skip: got wir/wpc/we=%b ret=%0d want 110 3", {write_ir, write_pc, rf_we}, retired);
      end
      W_IR_valid = 1'b1;
   endtask

   task automatic test_logical_flags();
      // ANDS: N,Z from ALU, C from shifter, V kept (0).
      IR = 32'hE2100001; alu_nzcv = 4'b1001; shift_carry = 1'b1;
      repeat (3) @(negedge clk);
      n_tests++;
      if (rf_we !== 1'b1 || rf_wa !== 4'd0) begin
         n_fail++; $display("FAIL ands_wb: got we=%b wa=%0d want 1 0", rf_we, rf_wa);
      end
      @(negedge clk);
      n_tests++;
      if (NZCV !== 4'b1010 || retired !== 16'd4) begin
         n_fail++; $display("FAIL ands_flags: got nzcv=%b ret=%0d want 1010 4", NZCV, retired);
      end
   endtask

   task automatic test_test_ops();
      // CMN: arithmetic, loads all four bits, no write.
      IR = 32'hE3710000; alu_nzcv = 4'b0011; shift_carry = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL cmn_no_write: got we=%b want 0", rf_we); end
      @(negedge clk);
      n_tests++;
      if (NZCV !== 4'b0011 || retired !== 16'd5) begin
         n_fail++; $display("FAIL cmn_flags: got nzcv=%b ret=%0d want 0011 5", NZCV, retired);
      end
      // TST with S=0 still updates flags; logical, V kept (1).
      IR = 32'hE3000000; alu_nzcv = 4'b0100; shift_carry = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (rf_we !== 1'b0) begin n_fail++; $display("FAIL tst_no_write: got we=%b want 0", rf_we); end
      @(negedge clk);
      n_tests++;
      if (NZCV !== 4'b0101 || retired !== 16'd6) begin
         n_fail++; $display("FAIL tst_flags: got nzcv=%b ret=%0d want 0101 6", NZCV, retired);
      end
   endtask

   task automatic test_illegal();
      IR = 32'hEA000000; W_IR_valid = 1'b1; alu_nzcv = 4'b1111; shift_carry = 1'b1;
      @(negedge clk); // DECODE
      n_tests++;
      if (illegal !== 1'b1 || rf_we !== 1'b0) begin
         n_fail++; $display("FAIL illegal_pulse: got ill=%b we=%b want 1 0", illegal, rf_we);
      end
      @(negedge clk); // back in FETCH
      n_tests++;
      if (write_ir !== 1'b1 || illegal !== 1'b0 || NZCV !== 4'b0101 || retired !== 16'd6) begin
         n_fail++; $display("FAIL illegal_after: got wir=%b ill=%b nzcv=%b ret=%0d want 1 0 0101 6", write_ir, illegal, NZCV, retired);
      end
   endtask

   task automatic test_run_low();
      // ADD R3,R2,R1,ASR #3 with run dropped mid-instruction.
      IR = 32'hE08231C1; W_IR_valid = 1'b1; alu_nzcv = 4'b1111;
      @(negedge clk); // DECODE
      n_tests++;
      if (rf_ra !== 4'd2 || rf_rb !== 4'd1) begin
         n_fail++; $display("FAIL reg_decode: got ra=%0d rb=%0d want 2 1", rf_ra, rf_rb);
      end
      run = 1'b0;
      @(negedge clk); // EXEC
      n_tests++;
      if (op2_imm !== 1'b0 || shift_type !== 2'd2 || shift_amt !== 5'd3 || alu_op !== 4'h4) begin
         n_fail++; $display("FAIL reg_exec: got op2i=%b st=%0d sa=%0d op=%h want 0 2 3 4", op2_imm, shift_type, shift_amt, alu_op);
      end
      @(negedge clk); // WB
      n_tests++;
      if (rf_we !== 1'b1 || rf_wa !== 4'd3) begin
         n_fail++; $display("FAIL reg_wb: got we=%b wa=%0d want 1 3", rf_we, rf_wa);
      end
      repeat (2) @(negedge clk); // IDLE
      n_tests++;
      if ({write_ir, write_pc} !== 2'b00 || retired !== 16'd7 || NZCV !== 4'b0101) begin
         n_fail++; $display("FAIL idle_hold: got wir/wpc=%b ret=%0d nzcv=%b want 00 7 0101", {write_ir, write_pc}, retired, NZCV);
      end
      run = 1'b1;
      @(negedge clk);
      n_tests++;
      if (write_ir !== 1'b1) begin n_fail++; $display("FAIL idle_restart: got wir=%b want 1", write_ir); end
   endtask

   task automatic test_mid_reset();
      IR = 32'hE2911005; W_IR_valid = 1'b1; alu_nzcv = 4'b1111; shift_carry = 1'b1;
      repeat (2) @(negedge clk); // EXEC
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({write_ir, rf_we} !== 2'b00 || NZCV !== 4'b0000 || retired !== '0) begin
         n_fail++; $display("FAIL midrst_abort: got wir/we=%b nzcv=%b ret=%0d want 00 0000 0", {write_ir, rf_we}, NZCV, retired);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_tests++;
         if (rf_we !== 1'b0 || NZCV !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_hold: cycle %0d got we=%b nzcv=%b want 0 0000", c, rf_we, NZCV);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (write_ir !== 1'b1) begin n_fail++; $display("FAIL midrst_restart: got wir=%b want 1", write_ir); end
   endtask

   initial begin
      test_reset();
      test_adds();
      test_cmp();
      test_mov_rot();
      test_skip();
      test_logical_flags();
      test_test_ops();
      test_illegal();
      test_run_low();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard stop so a stuck DUT can never hang the run.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_control_unit.md
# instr_control_unit

Multi-cycle control unit that sits directly downstream of the instruction-fetch stage. It consumes the latched 32-bit instruction word and the fetch stage's condition-pass indication. It drives the fetch-stage strobes (`write_ir`, `write_pc`), sequences register-file read, ALU execute and write-back for the data-processing instruction class, and owns the architectural NZCV flag register that the fetch stage uses to evaluate condition codes.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `run` input 1: when high, permits starting a new fetch.
- `IR` input 32: instruction word from the fetch stage, valid from the negedge following `write_ir`.
- `W_IR_valid` input 1: the fetch stage's condition-pass indication, qualified by `write_ir`.
- `alu_nzcv` input 4: ALU flag result {N,Z,C,V}.
- `shift_carry` input 1: barrel-shifter carry-out, used by logical ops.
- `write_ir` output 1: fetch strobe.
- `write_pc` output 1: PC increment strobe.
- `rf_ra`, `rf_rb` output 4 each: read addresses, Rn and Rm.
- `rf_wa` output 4: write address, Rd.
- `rf_we` output 1: register-file write enable.
- `alu_op` output 4: the instruction's opcode field.
- `op2_imm` output 1: 1 = use `imm32`; 0 = use the shifted Rm.
- `imm32` output 32: `IR[7:0]` rotated right by `2*IR[11:8]`.
- `shift_type` output 2: `IR[6:5]`.
- `shift_amt` output 5: `IR[11:7]`.
- `NZCV` output 4: flag register, fed to the fetch stage.
- `illegal` output 1: one-cycle pulse on a non-data-processing instruction.
- `retired` output `CNT_W`: count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB. Control outputs are Moore-decoded from the state register only.
- IDLE
  - All strobes low.
  - `run`=1 → FETCH. Otherwise stay in IDLE.
- FETCH
  - `write_ir`=1, `write_pc`=1.
  - `W_IR_valid`=1 → DECODE.
  - `W_IR_valid`=0: the instruction is skipped because its condition failed. The PC has still advanced. Next state is FETCH if `run`=1, else IDLE. `retired` is unchanged.
- DECODE
  - Drive `rf_ra`=`IR[19:16]` and `rf_rb`=`IR[3:0]`.
  - If `IR[27:26]`≠00: pulse `illegal`, then go to FETCH or IDLE according to `run`. No write, no flag change.
  - Otherwise → EXEC.
- EXEC
  - Drive `alu_op`, `op2_imm`=`IR[25]`, `imm32`, `shift_type`, `shift_amt`.
  - → WB.
- WB
  - `rf_we`=1 and `rf_wa`=`IR[15:12]`, except for opcodes 1000–1011 (TST, TEQ, CMP, CMN), which perform no write.
  - Flag update when `IR[20]`=1, or always for opcodes 1000–1011:
    - Arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN) load all four bits of `alu_nzcv`.
    - Logical ops load N and Z from `alu_nzcv`, load C from `shift_carry`, and keep V.
  - `retired` increments by 1, wrapping modulo 2^`CNT_W`.
  - Next state: FETCH if `run`=1, else IDLE.
- `imm32`, address and operand outputs are combinational from `IR`. They are valid only in the states listed above; a bench checks them only in those states.
- `run` is sampled only at the IDLE, skipped-FETCH, illegal-DECODE and WB exits. Deasserting it mid-instruction lets the current instruction complete.

## Timing
- Reset values: state=IDLE, `NZCV`=4'b0000, `retired`=0, every strobe and `illegal`=0.
- Reset asserted mid-instruction: abandon the instruction immediately. No `rf_we` pulse, no flag update.
- IR handoff:
  - `write_ir` is high through the whole FETCH cycle.
  - The fetch stage latches IR on the falling edge inside that cycle.
  - DECODE, at the next rising edge, sees the new IR.
- Latency:
  - Executed instruction: 4 cycles from FETCH entry to the WB exit.
  - Skipped instruction: 1 cycle.
  - Illegal instruction: 2 cycles.
- `NZCV` changes on the rising edge that ends WB. The next FETCH's condition check therefore uses the updated flags (back-to-back dependency).
- `retired` increments on that same edge.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state encoding;
  - the 16 opcode localparams;
  - the flag bit positions N=3, Z=2, C=1, V=0, shared with the fetch stage;
  - a function `is_test_op(opcode)` for opcodes 1000–1011.
- One sub-module, `op2_imm_rotate`: combinational 8-bit rotate-right immediate expander, input `IR[11:0]`, output `imm32`.
- The FSM, flag register and counter stay in the top module.

## Test plan
- Reset: assert `rst_n`=0 for 3 cycles with `run`=1 → all outputs at their reset values; the first `write_ir` appears one cycle after reset release.
- ADDS: `IR`=E2911005 (ADDS R1,R1,#5), `W_IR_valid`=1, `alu_nzcv`=4'b0000 → in WB: `rf_we`=1, `rf_wa`=1, `imm32`=5, `op2_imm`=1; `NZCV`=0000; `retired`=1 after 4 cycles.
- CMP: `IR`=E3520000 (CMP R2,#0), `alu_nzcv`=0110 → `rf_we` never high; `NZCV`=0110 after WB.
- Skipped instruction: `W_IR_valid`=0 during FETCH → back in FETCH next cycle; no `rf_we`; `retired` unchanged; `write_pc` was high for 1 cycle.
- MOV with rotated immediate: `IR`=E3A004FF → `imm32`=FF000000; NZCV unchanged because S=0.
- Illegal and mid-instruction reset:
  - `IR`=EA000000 → 1-cycle `illegal` pulse in DECODE, then FETCH.
  - Separately, assert `rst_n` low during EXEC → state IDLE; no `rf_we` pulse; `NZCV` unchanged from its reset value.
